// File: rtl/ll_sched_pkg.sv
// Shared types and the round-robin pick helper for ll_fifo_scheduler.
package ll_sched_pkg;

   localparam int LL_WIDTH     = 8;
   localparam int LL_DEPTH     = 4;
   localparam int LL_NUM_FIFOS = 2;
   localparam int LL_SEL_WIDTH = $clog2(LL_NUM_FIFOS);
   localparam int LL_CNT_WIDTH = $clog2(LL_DEPTH + 1);

   typedef logic [LL_SEL_WIDTH-1:0] sel_t;
   typedef logic [LL_CNT_WIDTH-1:0] cnt_t;

   // Requesters beyond the real count are tied low, so wrapping at the
   // power-of-2 span gives the same order as wrapping at NUM_FIFOS.
   localparam int RR_MAX_REQ = 16;
   localparam int RR_IDX_W   = 4;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] index;
   } rr_pick_t;

   function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                        input logic [RR_IDX_W-1:0]   ptr);
      rr_pick_t            res;
      logic [RR_IDX_W-1:0] idx;
      res = '0;
      for (int k = 0; k < RR_MAX_REQ; k++) begin
         idx = ptr + RR_IDX_W'(k);
         if (!res.found && req[idx]) begin
            res.found = 1'b1;
            res.index = idx;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ll_fifo_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping; one-hot grant.
module ll_rr_arbiter
   import ll_sched_pkg::*;
#(
   parameter int N    = 2,
   parameter int SELW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [SELW-1:0] index
);

   logic [RR_MAX_REQ-1:0] req_ext;
   logic [RR_IDX_W-1:0]   ptr_ext;
   logic [RR_IDX_W-1:0]   unused_pick_idx;
   rr_pick_t              pick;

   always_comb begin
      req_ext          = '0;
      req_ext[N-1:0]   = req;
      ptr_ext          = '0;
      ptr_ext[SELW-1:0] = ptr;
      pick             = rr_pick(req_ext, ptr_ext);
      unused_pick_idx  = pick.index;
      index            = pick.index[SELW-1:0];
      grant            = '0;
      if (pick.found) grant[index] = 1'b1;
   end

endmodule

// File: rtl/ll_fifo_scheduler.sv
// Shares one linked_list_fifo among NUM_FIFOS queues: RR push arbitration,
// RR pop scheduling into a registered output stage, per-queue occupancy.
// LL_SCHED_RESERVE_EN: keep one free entry reserved for every idle queue.
module ll_fifo_scheduler
   import ll_sched_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int NUM_FIFOS = 2,
   parameter int SEL_WIDTH = $clog2(NUM_FIFOS),
   parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_FIFOS-1:0]           in_valid,
   input  logic [NUM_FIFOS*WIDTH-1:0]     in_data,
   output logic [NUM_FIFOS-1:0]           in_ready,
   output logic                           out_valid,
   output logic [SEL_WIDTH-1:0]           out_sel,
   output logic [WIDTH-1:0]               out_data,
   input  logic [NUM_FIFOS-1:0]           out_ready,
   output logic                           ll_push,
   output logic                           ll_pop,
   output logic [SEL_WIDTH-1:0]           ll_push_sel,
   output logic [SEL_WIDTH-1:0]           ll_pop_sel,
   output logic [WIDTH-1:0]               ll_data_in,
   input  logic                           ll_full,
   input  logic [NUM_FIFOS-1:0]           ll_empty,
   input  logic [WIDTH-1:0]               ll_data_out,
   output logic [NUM_FIFOS*CNT_WIDTH-1:0] count
);

   logic [SEL_WIDTH-1:0] push_ptr, pop_ptr, push_idx, pop_idx;
   logic [NUM_FIFOS-1:0] push_ok, push_req, push_grant, pop_req, pop_grant;
   logic [CNT_WIDTH-1:0] cnt_q [NUM_FIFOS];
   logic                 out_free;
   int                   count_total;

   function automatic logic [SEL_WIDTH-1:0] ptr_next(input logic [SEL_WIDTH-1:0] p);
      return (p == SEL_WIDTH'(NUM_FIFOS - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      count_total = 0;
      for (int i = 0; i < NUM_FIFOS; i++) count_total += int'(cnt_q[i]);
   end

`ifdef LL_SCHED_RESERVE_EN
   // Free space must exceed the entries owed to the other idle queues.
   always_comb begin
      int n_idle;
      int owed;
      push_ok = '0;
      n_idle  = 0;
      owed    = 0;
      for (int i = 0; i < NUM_FIFOS; i++)
         if (cnt_q[i] == '0) n_idle++;
      for (int i = 0; i < NUM_FIFOS; i++) begin
         owed       = n_idle - ((cnt_q[i] == '0) ? 1 : 0);
         push_ok[i] = !ll_full && ((DEPTH - count_total) > owed);
      end
   end
`else
   always_comb push_ok = {NUM_FIFOS{!ll_full}};
`endif

   assign push_req = in_valid & push_ok & {NUM_FIFOS{!rst}};
   assign out_free = !out_valid || out_ready[out_sel];
   assign pop_req  = ~ll_empty & {NUM_FIFOS{out_free && !rst}};

   ll_rr_arbiter #(.N(NUM_FIFOS), .SELW(SEL_WIDTH)) u_push_arb (
      .req   (push_req),
      .ptr   (push_ptr),
      .grant (push_grant),
      .index (push_idx)
   );

   ll_rr_arbiter #(.N(NUM_FIFOS), .SELW(SEL_WIDTH)) u_pop_arb (
      .req   (pop_req),
      .ptr   (pop_ptr),
      .grant (pop_grant),
      .index (pop_idx)
   );

   assign in_ready    = push_grant;
   assign ll_push     = |push_grant;
   assign ll_push_sel = push_idx;
   assign ll_data_in  = in_data[int'(push_idx)*WIDTH +: WIDTH];
   assign ll_pop      = |pop_grant;
   assign ll_pop_sel  = pop_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         push_ptr  <= '0;
         pop_ptr   <= '0;
         out_valid <= 1'b0;
         out_sel   <= '0;
         out_data  <= '0;
         for (int i = 0; i < NUM_FIFOS; i++) cnt_q[i] <= '0;
      end else begin
         if (ll_push) push_ptr <= ptr_next(push_idx);
         if (ll_pop) begin
            pop_ptr   <= ptr_next(pop_idx);
            out_valid <= 1'b1;
            out_sel   <= pop_idx;
            out_data  <= ll_data_out;
         end else if (out_valid && out_ready[out_sel]) begin
            out_valid <= 1'b0;
         end
         for (int i = 0; i < NUM_FIFOS; i++) begin
            case ({push_grant[i], pop_grant[i]})
               2'b10:   cnt_q[i] <= cnt_q[i] + 1'b1;
               2'b01:   cnt_q[i] <= cnt_q[i] - 1'b1;
               default: ;
            endcase
         end
      end
   end

   for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_cnt
      assign count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];

      a_cnt_over : assert property (@(posedge clk) disable iff (rst)
         (push_grant[g] && !pop_grant[g]) |-> (cnt_q[g] != CNT_WIDTH'(DEPTH)));
      a_cnt_under : assert property (@(posedge clk) disable iff (rst)
         (pop_grant[g] && !push_grant[g]) |-> (cnt_q[g] != '0));
   end

   a_pop_empty : assert property (@(posedge clk) disable iff (rst)
      ll_pop |-> !ll_empty[ll_pop_sel]);
   a_push_full : assert property (@(posedge clk) disable iff (rst)
      ll_push |-> !ll_full);
   a_ready_1h0 : assert property (@(posedge clk) disable iff (rst)
      $onehot0(in_ready));
   a_total : assert property (@(posedge clk) disable iff (rst)
      count_total <= DEPTH);

endmodule

// File: tb/tb_ll_fifo_scheduler.sv
// Directed table-driven bench for ll_fifo_scheduler with a behavioural linked-list FIFO.
module tb_ll_fifo_scheduler;
   import ll_sched_pkg::*;

   localparam int W = 8, D = 4, NQ = 2, SW = 1, CW = 3;

`ifdef LL_SCHED_RESERVE_EN
   localparam int EXP_Q0_ACC = 4, EXP_Q0_CNT = 3, EXP_Q1_ACC = 1;
`else
   localparam int EXP_Q0_ACC = 5, EXP_Q0_CNT = 4, EXP_Q1_ACC = 0;
`endif

   logic              clk, rst;
   logic [NQ-1:0]     in_valid, in_ready, out_ready, ll_empty;
   logic [NQ*W-1:0]   in_data;
   logic              out_valid, ll_push, ll_pop, ll_full;
   logic [SW-1:0]     out_sel, ll_push_sel, ll_pop_sel;
   logic [W-1:0]      out_data, ll_data_in, ll_data_out;
   logic [NQ*CW-1:0]  count;

   ll_fifo_scheduler #(.WIDTH(W), .DEPTH(D), .NUM_FIFOS(NQ)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_sel(out_sel), .out_data(out_data), .out_ready(out_ready),
      .ll_push(ll_push), .ll_pop(ll_pop), .ll_push_sel(ll_push_sel), .ll_pop_sel(ll_pop_sel),
      .ll_data_in(ll_data_in), .ll_full(ll_full), .ll_empty(ll_empty),
      .ll_data_out(ll_data_out), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural shared FIFO: one circular buffer per queue, DEPTH entries total.
   logic [W-1:0] mq [NQ][D];
   logic [1:0]   mrp [NQ];
   logic [1:0]   mwp [NQ];
   cnt_t         mcnt [NQ];

   always @(posedge clk) begin
      for (int q = 0; q < NQ; q++) begin
         if (rst) begin
            mrp[q]  <= '0;
            mwp[q]  <= '0;
            mcnt[q] <= '0;
         end else begin
            if (ll_push && ll_push_sel == 1'(q)) begin
               mq[q][mwp[q]] <= ll_data_in;
               mwp[q]        <= mwp[q] + 2'd1;
            end
            if (ll_pop && ll_pop_sel == 1'(q)) mrp[q] <= mrp[q] + 2'd1;
            mcnt[q] <= mcnt[q] + 3'(ll_push && ll_push_sel == 1'(q))
                               - 3'(ll_pop && ll_pop_sel == 1'(q));
         end
      end
   end

   assign ll_full     = (mcnt[0] + mcnt[1]) == 3'd4;
   assign ll_empty    = {mcnt[1] == '0, mcnt[0] == '0};
   assign ll_data_out = mq[ll_pop_sel][mrp[ll_pop_sel]];

   typedef struct {
      logic       rst;
      logic [1:0] iv;
      logic [7:0] d0, d1;
      logic [1:0] ordy;
      logic [1:0] e_rdy;
      logic       e_pop, e_psel;
      logic       e_ov;
      logic [7:0] e_od;
      logic       e_os;
      cnt_t       e_c0, e_c1;
   } vec_t;

   vec_t vecs[$];
   int   n_total = 0;
   int   n_pass  = 0;

   function automatic vec_t mk(input int r, iv, d0, d1, ordy, erdy, epop, epsel,
                               input int eov, eod, eos, c0, c1);
      vec_t v;
      v.rst = 1'(r);     v.iv = 2'(iv);       v.d0 = 8'(d0);     v.d1 = 8'(d1);
      v.ordy = 2'(ordy); v.e_rdy = 2'(erdy);  v.e_pop = 1'(epop); v.e_psel = 1'(epsel);
      v.e_ov = 1'(eov);  v.e_od = 8'(eod);    v.e_os = 1'(eos);
      v.e_c0 = 3'(c0);   v.e_c1 = 3'(c1);
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s (step %0d): got 0x%0h, want 0x%0h", name, idx, act, exp);
   endtask

   task automatic apply(input vec_t v, input int idx);
      rst       = v.rst;
      in_valid  = v.iv;
      in_data   = {v.d1, v.d0};
      out_ready = v.ordy;
      #1;
      chk("in_ready", idx, 32'(in_ready), 32'(v.e_rdy));
      chk("ll_push", idx, 32'(ll_push), 32'(|v.e_rdy));
      if (|v.e_rdy) begin
         chk("ll_push_sel", idx, 32'(ll_push_sel), 32'(v.e_rdy[1]));
         chk("ll_data_in", idx, 32'(ll_data_in), 32'(v.e_rdy[1] ? v.d1 : v.d0));
      end
      chk("ll_pop", idx, 32'(ll_pop), 32'(v.e_pop));
      if (v.e_pop) chk("ll_pop_sel", idx, 32'(ll_pop_sel), 32'(v.e_psel));
      @(posedge clk);
      #1;
      chk("out_valid", idx, 32'(out_valid), 32'(v.e_ov));
      chk("out_data", idx, 32'(out_data), 32'(v.e_od));
      chk("out_sel", idx, 32'(out_sel), 32'(v.e_os));
      chk("count0", idx, 32'(count[0 +: CW]), 32'(v.e_c0));
      chk("count1", idx, 32'(count[CW +: CW]), 32'(v.e_c1));
   endtask

   initial begin
      int acc0, acc1;
      rst = 1'b1; in_valid = '0; in_data = '0; out_ready = '0;

      // Fields: rst, in_valid, d0, d1, out_ready | in_ready, pop, pop_sel | out_valid, out_data, out_sel, cnt0, cnt1
      // Both producers every cycle, consumers stalled: pushes alternate until full.
      vecs.push_back(mk(0, 3, 'hA0, 'hB0, 0,  1, 0, 0,  0, 'h00, 0, 1, 0));
      vecs.push_back(mk(0, 3, 'hA1, 'hB1, 0,  2, 1, 0,  1, 'hA0, 0, 0, 1));
      vecs.push_back(mk(0, 3, 'hA2, 'hB2, 0,  1, 0, 0,  1, 'hA0, 0, 1, 1));
      vecs.push_back(mk(0, 3, 'hA3, 'hB3, 0,  2, 0, 0,  1, 'hA0, 0, 1, 2));
      vecs.push_back(mk(0, 3, 'hA4, 'hB4, 0,  1, 0, 0,  1, 'hA0, 0, 2, 2));
      vecs.push_back(mk(0, 3, 'hA5, 'hB5, 0,  0, 0, 0,  1, 'hA0, 0, 2, 2));
      // Full: a pop proceeds with in_ready=0, then q1 is accepted next cycle.
      vecs.push_back(mk(0, 2, 'h00, 'hC6, 1,  0, 1, 1,  1, 'hB1, 1, 2, 1));
      vecs.push_back(mk(0, 2, 'h00, 'hC7, 0,  2, 0, 0,  1, 'hB1, 1, 2, 2));
      // Consumer 1 stalled for 3 cycles (consumer 0 ready but not selected).
      vecs.push_back(mk(0, 0, 'h00, 'h00, 1,  0, 0, 0,  1, 'hB1, 1, 2, 2));
      vecs.push_back(mk(0, 0, 'h00, 'h00, 1,  0, 0, 0,  1, 'hB1, 1, 2, 2));
      vecs.push_back(mk(0, 0, 'h00, 'h00, 1,  0, 0, 0,  1, 'hB1, 1, 2, 2));
      // Release: drain and pop in the same cycle, then back-to-back drain.
      vecs.push_back(mk(0, 0, 'h00, 'h00, 2,  0, 1, 0,  1, 'hA2, 0, 1, 2));
      vecs.push_back(mk(0, 0, 'h00, 'h00, 3,  0, 1, 1,  1, 'hB3, 1, 1, 1));
      vecs.push_back(mk(0, 0, 'h00, 'h00, 3,  0, 1, 0,  1, 'hA4, 0, 0, 1));
      vecs.push_back(mk(0, 0, 'h00, 'h00, 3,  0, 1, 1,  1, 'hC7, 1, 0, 0));
      vecs.push_back(mk(0, 0, 'h00, 'h00, 3,  0, 0, 0,  0, 'hC7, 1, 0, 0));
      vecs.push_back(mk(1, 0, 'h00, 'h00, 0,  0, 0, 0,  0, 'h00, 0, 0, 0));
      // Preload q0={11,12}, q1={21} behind a stalled output, then drain 11,21,12.
      vecs.push_back(mk(0, 1, 'h11, 'h00, 0,  1, 0, 0,  0, 'h00, 0, 1, 0));
      vecs.push_back(mk(0, 1, 'h12, 'h00, 0,  1, 1, 0,  1, 'h11, 0, 1, 0));
      vecs.push_back(mk(0, 2, 'h00, 'h21, 0,  2, 0, 0,  1, 'h11, 0, 1, 1));
      vecs.push_back(mk(0, 0, 'h00, 'h00, 3,  0, 1, 1,  1, 'h21, 1, 1, 0));
      vecs.push_back(mk(0, 0, 'h00, 'h00, 3,  0, 1, 0,  1, 'h12, 0, 0, 0));
      vecs.push_back(mk(0, 0, 'h00, 'h00, 3,  0, 0, 0,  0, 'h12, 0, 0, 0));
      // Build count=2,1 with out_valid=1 and push_ptr=1, then reset mid-operation.
      vecs.push_back(mk(0, 3, 'h31, 'h41, 0,  1, 0, 0,  0, 'h12, 0, 1, 0));
      vecs.push_back(mk(0, 3, 'h32, 'h42, 0,  2, 1, 0,  1, 'h31, 0, 0, 1));
      vecs.push_back(mk(0, 3, 'h33, 'h43, 0,  1, 0, 0,  1, 'h31, 0, 1, 1));
      vecs.push_back(mk(0, 1, 'h34, 'h00, 0,  1, 0, 0,  1, 'h31, 0, 2, 1));
      vecs.push_back(mk(1, 3, 'h35, 'h45, 3,  0, 0, 0,  0, 'h00, 0, 0, 0));
      vecs.push_back(mk(0, 3, 'h35, 'h45, 0,  1, 0, 0,  0, 'h00, 0, 1, 0));
      vecs.push_back(mk(0, 0, 'h00, 'h00, 3,  0, 1, 0,  1, 'h35, 0, 0, 0));

      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", -1, 32'(out_valid), 32'd0);
      chk("reset out_data", -1, 32'(out_data), 32'd0);
      chk("reset count", -1, 32'(count), 32'd0);

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // Single active producer with consumers stalled; then the other producer.
      rst = 1'b1; in_valid = '0; out_ready = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      acc0 = 0;
      acc1 = 0;
      in_valid = 2'b01;
      for (int c = 0; c < 8; c++) begin
         in_data = {8'h00, 8'(8'h50 + c)};
         #1;
         if (in_ready[0]) acc0++;
         @(posedge clk);
         #1;
      end
      chk("q0 accepted", 100, 32'(acc0), 32'(EXP_Q0_ACC));
      chk("q0 count", 100, 32'(count[0 +: CW]), 32'(EXP_Q0_CNT));
      in_valid = 2'b10;
      for (int c = 0; c < 4; c++) begin
         in_data = {8'(8'h60 + c), 8'h00};
         #1;
         if (in_ready[1]) acc1++;
         @(posedge clk);
         #1;
      end
      chk("q1 accepted", 101, 32'(acc1), 32'(EXP_Q1_ACC));
      chk("q1 count", 101, 32'(count[CW +: CW]), 32'(EXP_Q1_ACC));
      chk("q1 in_ready idle", 101, 32'(in_ready), 32'd0);
      in_valid = '0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
